// File: rtl/wb_cmd_master.sv
// wb_cmd_master: turns single read/write commands into pipelined Wishbone cycles.
//
// One transaction is outstanding at a time. A command accepted in IDLE is
// latched onto the bus signals, the strobe is held until the slave stops
// stalling, and the cycle ends on ack, err or timeout. The result is presented
// on the response port until consumed.
//
// Ports:
//   i_clk, i_reset_n          clock, synchronous active-low reset
//   i_cmd_valid/o_cmd_ready   command handshake (ready only in IDLE)
//   i_cmd_we/addr/data        command fields
//   o_rsp_valid/i_rsp_ready   response handshake
//   o_rsp_data/o_rsp_err      read data (0 for writes/errors), error flag
//   o_wb_*                    Wishbone master outputs (cyc, stb, we, addr, data)
//   i_wb_stall/ack/err/data   Wishbone slave inputs
module wb_cmd_master #(
  parameter int unsigned AW = 1,
  parameter int unsigned DW = 32,
  parameter int unsigned TW = 4
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic          i_cmd_we,
  input  logic [AW-1:0] i_cmd_addr,
  input  logic [DW-1:0] i_cmd_data,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [DW-1:0] o_rsp_data,
  output logic          o_rsp_err,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  input  logic [DW-1:0] i_wb_data
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  localparam logic [TW-1:0] CntLimit = '1;

  state_e        r_state;
  state_e        w_state_next;
  logic [TW-1:0] r_cnt;
  logic [TW-1:0] w_cnt_inc;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_rsp_err;
  logic [DW-1:0] r_rsp_data;
  logic          w_accept;
  logic          w_bus_ack;
  logic          w_bus_err;
  logic          w_timeout;

  // Next state and decoded outputs.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_bus_ack    = 1'b0;
    w_bus_err    = 1'b0;
    w_timeout    = 1'b0;
    w_cnt_inc    = r_cnt + TW'(1);
    o_cmd_ready  = 1'b0;
    o_wb_cyc     = 1'b0;
    o_wb_stb     = 1'b0;
    o_rsp_valid  = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          w_accept     = 1'b1;
          w_state_next = StReq;
        end
      end
      StReq, StWait: begin
        o_wb_cyc  = 1'b1;
        o_wb_stb  = (r_state == StReq);
        // err wins over ack; either wins over a timeout in the same cycle.
        w_bus_err = i_wb_err;
        w_bus_ack = i_wb_ack && !i_wb_err;
        // The counter value after this cycle's increment is compared, so the
        // cycle ends after exactly CntLimit cycles with cyc high.
        w_timeout = !i_wb_ack && !i_wb_err && (w_cnt_inc == CntLimit);
        if (w_bus_err || w_bus_ack || w_timeout) begin
          w_state_next = StResp;
        end else if ((r_state == StReq) && !i_wb_stall) begin
          w_state_next = StWait;
        end
      end
      StResp: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Bus fields only load on accept, so they are frozen for the whole cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_rsp_err  <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      if (w_accept) begin
        r_we   <= i_cmd_we;
        r_addr <= i_cmd_addr;
        r_data <= i_cmd_data;
        r_cnt  <= '0;
      end else if (o_wb_cyc) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_bus_ack) begin
        r_rsp_err  <= 1'b0;
        r_rsp_data <= r_we ? '0 : i_wb_data;
      end else if (w_bus_err || w_timeout) begin
        r_rsp_err  <= 1'b1;
        r_rsp_data <= '0;
      end
    end
  end

  assign o_wb_we    = r_we;
  assign o_wb_addr  = r_addr;
  assign o_wb_data  = r_data;
  assign o_rsp_data = r_rsp_data;
  assign o_rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed and randomized transactions against a
// transaction-level model (response time, stall length, outcome).
module tb_wb_cmd_master;

  localparam int unsigned AW = 1;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 4;
  localparam int Limit = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_stall;
  logic          wb_ack;
  logic          wb_err;
  logic [DW-1:0] wb_rdata;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  wb_cmd_master #(
    .AW(AW),
    .DW(DW),
    .TW(TW)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_we   (cmd_we),
    .i_cmd_addr (cmd_addr),
    .i_cmd_data (cmd_data),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_data (rsp_data),
    .o_rsp_err  (rsp_err),
    .o_wb_cyc   (wb_cyc),
    .o_wb_stb   (wb_stb),
    .o_wb_we    (wb_we),
    .o_wb_addr  (wb_addr),
    .o_wb_data  (wb_data),
    .i_wb_stall (wb_stall),
    .i_wb_ack   (wb_ack),
    .i_wb_err   (wb_err),
    .i_wb_data  (wb_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic junk_cmd();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_we    = 1'($urandom_range(0, 1));
    cmd_addr  = AW'($urandom_range(0, 1));
    cmd_data  = DW'($urandom);
  endtask

  // kind: 0 = ack, 1 = err (with ack too when both=1), 2 = slave silent.
  // The slave answers in the r-th cycle of cyc, r = stall_n + 1 + wait_n.
  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input int stall_n, input int wait_n, input int kind, input logic both,
                         input logic [DW-1:0] rdata, input int hold_n);
    int            r;
    int            exp_len;
    int            k;
    logic          exp_err;
    logic [DW-1:0] exp_data;
    r = stall_n + 1 + wait_n;
    if (kind != 2 && r <= Limit) begin
      exp_len  = r;
      exp_err  = (kind == 1);
      exp_data = (kind == 0 && !we) ? rdata : '0;
    end else begin
      exp_len  = Limit;
      exp_err  = 1'b1;
      exp_data = '0;
    end
    check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_data  = data;
    @(posedge clk);
    @(negedge clk);
    k = 1;
    while (wb_cyc === 1'b1 && k <= Limit + 2) begin
      check("stb", 64'(wb_stb), 64'(k <= stall_n + 1));
      check("wb_fields", 64'({wb_we, wb_addr, wb_data}), 64'({we, addr, data}));
      check("cmd_ready_busy", 64'(cmd_ready), 64'(0));
      junk_cmd();
      wb_stall = (k <= stall_n);
      wb_ack   = (kind == 0 || (kind == 1 && both)) && k == r;
      wb_err   = (kind == 1) && k == r;
      wb_rdata = (k == r) ? rdata : DW'($urandom);
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check("cyc_len", 64'(k - 1), 64'(exp_len));
    // A late ack (r past the limit) lands here, after cyc has dropped.
    wb_stall = 1'b0;
    wb_ack   = (kind == 0) && k == r;
    wb_err   = 1'b0;
    wb_rdata = DW'($urandom);
    for (int h = 0; h <= hold_n; h++) begin
      check("rsp_valid", 64'(rsp_valid), 64'(1));
      check("rsp_err", 64'(rsp_err), 64'(exp_err));
      check("rsp_data", 64'(rsp_data), 64'(exp_data));
      check("cmd_ready_resp", 64'(cmd_ready), 64'(0));
      check("cyc_resp", 64'(wb_cyc), 64'(0));
      if (h == hold_n) begin
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
      end else begin
        rsp_ready = 1'b0;
        junk_cmd();
      end
      @(posedge clk);
      @(negedge clk);
      wb_ack = 1'b0;
      wb_err = 1'b0;
    end
    rsp_ready = 1'b0;
    check("rsp_valid_done", 64'(rsp_valid), 64'(0));
    check("cmd_ready_done", 64'(cmd_ready), 64'(1));
  endtask

  logic [DW-1:0] b_rd [4];
  logic          b_we [4];
  logic [AW-1:0] b_addr [4];
  logic [DW-1:0] b_wd [4];
  int            t;
  int            ph;
  int            kind;

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    wb_stall  = 1'b0;
    wb_ack    = 1'b0;
    wb_err    = 1'b0;
    wb_rdata  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cyc", 64'(wb_cyc), 64'(0));
    check("rst_stb", 64'(wb_stb), 64'(0));
    check("rst_fields", 64'({wb_we, wb_addr, wb_data}), 64'(0));
    check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_data}), 64'(0));
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(cmd_ready), 64'(1));
    check("rst_cyc_after", 64'(wb_cyc), 64'(0));

    // Write with zero-wait ack; read data on the bus must not leak into rsp.
    run_txn(1'b1, 1'b0, 32'h0000_0001, 0, 0, 0, 1'b0, 32'hDEAD_BEEF, 0);
    // Read, three stall cycles, ack two cycles later.
    run_txn(1'b0, 1'b1, 32'h1234_5678, 3, 2, 0, 1'b0, 32'h0000_00A5, 0);
    // Silent slave: timeout.
    run_txn(1'b0, 1'b0, 32'h0, 0, 0, 2, 1'b0, 32'h0, 0);
    // Ack in the limit cycle beats the timeout.
    run_txn(1'b0, 1'b1, 32'h0, 2, 12, 0, 1'b0, 32'h5A5A_0F0F, 1);
    // Ack one cycle too late: timeout, and the late ack is ignored.
    run_txn(1'b0, 1'b0, 32'h0, 0, 15, 0, 1'b0, 32'h1111_2222, 0);
    // Write answered with err, response held 5 cycles.
    run_txn(1'b1, 1'b1, 32'hCAFE_0001, 1, 1, 1, 1'b0, 32'h3333_4444, 5);
    // ack and err together count as err.
    run_txn(1'b0, 1'b0, 32'h0, 0, 1, 1, 1'b1, 32'h7777_8888, 2);

    // Reset while waiting, ack the cycle after.
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_wait_cyc", 64'({wb_cyc, wb_stb}), 64'(2'b10));
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_cyc", 64'(wb_cyc), 64'(0));
    reset_n  = 1'b1;
    wb_ack   = 1'b1;
    wb_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    @(negedge clk);
    wb_ack = 1'b0;
    check("mid_rst_norsp", 64'(rsp_valid), 64'(0));
    check("mid_rst_ready", 64'(cmd_ready), 64'(1));
    check("mid_rst_state", 64'({wb_cyc, rsp_err, rsp_data, wb_addr}), 64'(0));

    // Stray ack/err with cyc low.
    wb_ack = 1'b1;
    wb_err = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wb_ack = 1'b0;
    wb_err = 1'b0;
    check("stray_cyc", 64'(wb_cyc), 64'(0));
    check("stray_rsp", 64'(rsp_valid), 64'(0));
    check("stray_ready", 64'(cmd_ready), 64'(1));

    // Back-to-back commands, zero-wait acks, rsp_ready held high.
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      t  = c / 3;
      ph = c % 3;
      if (ph == 0) begin
        b_we[t]   = 1'($urandom_range(0, 1));
        b_addr[t] = AW'($urandom_range(0, 1));
        b_wd[t]   = DW'($urandom);
        b_rd[t]   = DW'($urandom);
        cmd_we    = b_we[t];
        cmd_addr  = b_addr[t];
        cmd_data  = b_wd[t];
      end
      check("b2b_ready", 64'(cmd_ready), 64'(ph == 0));
      check("b2b_stb", 64'(wb_stb), 64'(ph == 1));
      check("b2b_rsp_valid", 64'(rsp_valid), 64'(ph == 2));
      if (ph == 1) begin
        check("b2b_fields", 64'({wb_we, wb_addr, wb_data}), 64'({b_we[t], b_addr[t], b_wd[t]}));
      end
      if (ph == 2) begin
        check("b2b_rsp", 64'({rsp_err, rsp_data}), 64'({1'b0, b_we[t] ? '0 : b_rd[t]}));
      end
      wb_ack   = (ph == 1);
      wb_rdata = (ph == 1) ? b_rd[t] : DW'($urandom);
      if (c == 11) cmd_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    wb_ack    = 1'b0;
    rsp_ready = 1'b0;
    check("b2b_end_ready", 64'(cmd_ready), 64'(1));

    // Randomized transactions.
    for (int i = 0; i < 10; i++) begin
      kind = $urandom_range(0, 3);
      if (kind == 3) kind = 0;
      run_txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 1)), DW'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 5), kind, 1'($urandom_range(0, 1)),
              DW'($urandom), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
